// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: prioritised next-PC selection, IF/ID and ID/EX
// stall/flush generation, and redirect buffering across multi-cycle imem waits.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_imem_ready,
    input  logic        i_load_use,
    input  logic        i_exception,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_pc,
    output logic        o_pc_valid,
    output logic [31:0] o_epc,
    output logic        o_stall_if_id,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex
);

    localparam int              BC_W      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BC_W-1:0] BOOT_LAST = BC_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT
    } state_t;

    state_t          r_state, w_state_next;
    logic [31:0]     r_pc, w_pc_next;
    logic [31:0]     r_epc, w_epc_next;
    logic [BC_W-1:0] r_boot_cnt, w_boot_cnt_next;
    logic            r_pend_vld, w_pend_vld_next;
    logic [31:0]     r_pend_tgt, w_pend_tgt_next;

    logic            w_redirect;
    logic [31:0]     w_target;
    logic [31:0]     w_pc_inc;

    assign w_redirect = i_jr | i_branch_taken | i_jump;
    assign w_pc_inc   = r_pc + 32'd4;

    always_comb begin
        w_target = i_jump_target;
        if (i_jr)
            w_target = i_jr_target;
        else if (i_branch_taken)
            w_target = i_branch_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_epc      <= 32'h0;
            r_boot_cnt <= '0;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_epc      <= w_epc_next;
            r_boot_cnt <= w_boot_cnt_next;
            r_pend_vld <= w_pend_vld_next;
            r_pend_tgt <= w_pend_tgt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_epc_next      = r_epc;
        w_boot_cnt_next = r_boot_cnt;
        w_pend_vld_next = r_pend_vld;
        w_pend_tgt_next = r_pend_tgt;
        o_stall_if_id   = 1'b0;
        o_flush_if_id   = 1'b0;
        o_flush_id_ex   = 1'b0;

        unique case (r_state)
            S_BOOT: begin
                w_boot_cnt_next = r_boot_cnt + 1'b1;
                if (r_boot_cnt == BOOT_LAST)
                    w_state_next = S_FETCH;
            end

            S_FETCH: begin
                if (i_exception) begin
                    w_epc_next    = r_pc;
                    w_pc_next     = EXC_VECTOR;
                    o_flush_if_id = 1'b1;
                    o_flush_id_ex = 1'b1;
                end else if (i_load_use) begin
                    // ID will re-present any redirect once the hazard clears
                    o_stall_if_id = 1'b1;
                    o_flush_id_ex = 1'b1;
                end else if (w_redirect && i_imem_ready) begin
                    w_pc_next     = w_target;
                    o_flush_if_id = 1'b1;
                end else if (w_redirect) begin
                    w_pend_tgt_next = w_target;
                    w_pend_vld_next = 1'b1;
                    o_flush_if_id   = 1'b1;
                    w_state_next    = S_WAIT;
                end else if (i_imem_ready) begin
                    w_pc_next = w_pc_inc;
                end else begin
                    o_flush_if_id = 1'b1;
                    w_state_next  = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_exception) begin
                    w_epc_next      = r_pc;
                    w_pc_next       = EXC_VECTOR;
                    w_pend_vld_next = 1'b0;
                    o_flush_if_id   = 1'b1;
                    o_flush_id_ex   = 1'b1;
                    w_state_next    = S_FETCH;
                end else if (i_load_use) begin
                    // the returned word is discarded; the same pc is fetched again
                    o_stall_if_id = 1'b1;
                    o_flush_id_ex = 1'b1;
                end else if (i_imem_ready && r_pend_vld) begin
                    w_pc_next       = r_pend_tgt;
                    w_pend_vld_next = 1'b0;
                    o_flush_if_id   = 1'b1;
                    w_state_next    = S_FETCH;
                end else if (i_imem_ready && w_redirect) begin
                    w_pc_next     = w_target;
                    o_flush_if_id = 1'b1;
                    w_state_next  = S_FETCH;
                end else if (i_imem_ready) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_FETCH;
                end else begin
                    o_flush_if_id = 1'b1;
                    if (w_redirect && !r_pend_vld) begin
                        w_pend_tgt_next = w_target;
                        w_pend_vld_next = 1'b1;
                    end
                end
            end

            default: w_state_next = S_BOOT;
        endcase
    end

    assign o_pc       = r_pc;
    assign o_epc      = r_epc;
    assign o_pc_valid = (r_state != S_BOOT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives inputs, queues the expected
// outputs for that cycle, then pops and compares them before the next clock edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_imem_ready;
    logic        i_load_use;
    logic        i_exception;
    logic        i_jr;
    logic [31:0] i_jr_target;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic [31:0] o_pc;
    logic        o_pc_valid;
    logic [31:0] o_epc;
    logic        o_stall_if_id;
    logic        o_flush_if_id;
    logic        o_flush_id_ex;

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080),
        .BOOT_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_imem_ready    (i_imem_ready),
        .i_load_use      (i_load_use),
        .i_exception     (i_exception),
        .i_jr            (i_jr),
        .i_jr_target     (i_jr_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .o_pc            (o_pc),
        .o_pc_valid      (o_pc_valid),
        .o_epc           (o_epc),
        .o_stall_if_id   (o_stall_if_id),
        .o_flush_if_id   (o_flush_if_id),
        .o_flush_id_ex   (o_flush_id_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        valid;
        logic        stall;
        logic        fif;
        logic        fie;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_epc  = 32'h0;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s.%s: got %h expected %h", tag, field, obs, exp_v);
    endtask

    task automatic clear_inputs();
        i_imem_ready    = 1'b1;
        i_load_use      = 1'b0;
        i_exception     = 1'b0;
        i_jr            = 1'b0;
        i_jr_target     = 32'h0;
        i_branch_taken  = 1'b0;
        i_branch_target = 32'h0;
        i_jump          = 1'b0;
        i_jump_target   = 32'h0;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        chk(e.tag, "pc",          o_pc,                  e.pc);
        chk(e.tag, "epc",         o_epc,                 e.epc);
        chk(e.tag, "pc_valid",    {31'h0, o_pc_valid},   {31'h0, e.valid});
        chk(e.tag, "stall_if_id", {31'h0, o_stall_if_id}, {31'h0, e.stall});
        chk(e.tag, "flush_if_id", {31'h0, o_flush_if_id}, {31'h0, e.fif});
        chk(e.tag, "flush_id_ex", {31'h0, o_flush_id_ex}, {31'h0, e.fie});
        $display("step %-10s pc=%h epc=%h v=%b st=%b fif=%b fie=%b", e.tag, o_pc, o_epc,
                 o_pc_valid, o_stall_if_id, o_flush_if_id, o_flush_id_ex);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag, input logic [31:0] e_pc, input logic e_v,
                        input logic e_s, input logic e_fi, input logic e_fe);
        exp_t e;
        e.tag = tag; e.pc = e_pc; e.epc = exp_epc;
        e.valid = e_v; e.stall = e_s; e.fif = e_fi; e.fie = e_fe;
        sb_q.push_back(e);
        #2;
        check_out();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        step("rst",     32'h0,   0, 0, 0, 0);
        rst_n = 1'b1;
        step("boot0",   32'h0,   0, 0, 0, 0);
        step("boot1",   32'h0,   0, 0, 0, 0);
        step("f0",      32'h0,   1, 0, 0, 0);
        step("f4",      32'h4,   1, 0, 0, 0);
        i_branch_taken = 1'b1; i_branch_target = 32'h40;
        step("br",      32'h8,   1, 0, 1, 0);
        step("p40",     32'h40,  1, 0, 0, 0);
        i_load_use = 1'b1;
        step("lu",      32'h44,  1, 1, 0, 1);
        step("p44",     32'h44,  1, 0, 0, 0);
        i_load_use = 1'b1; i_jump = 1'b1; i_jump_target = 32'h200;
        step("lu_j",    32'h48,  1, 1, 0, 1);
        step("p48",     32'h48,  1, 0, 0, 0);

        // redirect arriving while imem is busy, then a second one that must be ignored
        i_imem_ready = 1'b0; i_jump = 1'b1; i_jump_target = 32'h100;
        step("w_j",     32'h4C,  1, 0, 1, 0);
        i_imem_ready = 1'b0;
        step("w1",      32'h4C,  1, 0, 1, 0);
        i_imem_ready = 1'b0; i_jr = 1'b1; i_jr_target = 32'h300;
        step("w_ign",   32'h4C,  1, 0, 1, 0);
        step("w_pend",  32'h4C,  1, 0, 1, 0);
        step("p100",    32'h100, 1, 0, 0, 0);

        i_jr = 1'b1; i_jr_target = 32'h500;
        i_branch_taken = 1'b1; i_branch_target = 32'h600;
        i_jump = 1'b1; i_jump_target = 32'h700;
        step("prio3",   32'h104, 1, 0, 1, 0);
        i_branch_taken = 1'b1; i_branch_target = 32'h600;
        i_jump = 1'b1; i_jump_target = 32'h700;
        step("prio2",   32'h500, 1, 0, 1, 0);

        i_imem_ready = 1'b0;
        step("f_wait",  32'h600, 1, 0, 1, 0);
        i_jump = 1'b1; i_jump_target = 32'h800;
        step("w_redir", 32'h600, 1, 0, 1, 0);
        i_imem_ready = 1'b0;
        step("f_wait2", 32'h800, 1, 0, 1, 0);
        step("w_seq",   32'h800, 1, 0, 0, 0);
        i_imem_ready = 1'b0;
        step("f_wait3", 32'h804, 1, 0, 1, 0);
        i_load_use = 1'b1;
        step("w_lu",    32'h804, 1, 1, 0, 1);
        step("w_seq2",  32'h804, 1, 0, 0, 0);

        // exception in WAIT with a pending branch: pending target must be dropped
        i_imem_ready = 1'b0; i_branch_taken = 1'b1; i_branch_target = 32'h900;
        step("w_br",    32'h808, 1, 0, 1, 0);
        i_imem_ready = 1'b0; i_exception = 1'b1;
        step("w_exc",   32'h808, 1, 0, 1, 1);
        exp_epc = 32'h808;
        step("p80",     32'h80,  1, 0, 0, 0);
        i_imem_ready = 1'b0;
        step("f_wait4", 32'h84,  1, 0, 1, 0);
        step("w_nopend",32'h84,  1, 0, 0, 0);
        i_exception = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h900;
        step("f_exc",   32'h88,  1, 0, 1, 1);
        exp_epc = 32'h88;

        i_jump = 1'b1; i_jump_target = 32'hFFFF_FFFC;
        step("j_top",   32'h80,  1, 0, 1, 0);
        step("wrap",    32'hFFFF_FFFC, 1, 0, 0, 0);
        step("p0",      32'h0,   1, 0, 0, 0);
        i_imem_ready = 1'b0;
        step("f_wait5", 32'h4,   1, 0, 1, 0);
        i_imem_ready = 1'b0; i_jump = 1'b1; i_jump_target = 32'h123;
        step("w_j2",    32'h4,   1, 0, 1, 0);

        // asynchronous reset asserted mid-cycle while waiting with a pending target
        i_imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        exp_epc = 32'h0;
        step("rst_mid", 32'h0,   0, 0, 0, 0);
        rst_n = 1'b1;
        step("boot0b",  32'h0,   0, 0, 0, 0);
        step("boot1b",  32'h0,   0, 0, 0, 0);
        step("rb0",     32'h0,   1, 0, 0, 0);
        step("rb4",     32'h4,   1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
